// File: rtl/morningjava_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: hex segment table,
// output polarity helper and index-width helper.
package morningjava_pkg;

  // gfedcba patterns for hex digits 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic inactive_level(input int active_low);
    return (active_low != 0);
  endfunction

  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/morningjava_seg7_scan_if.sv
// Data/display bundle between the data path (master) and the scanner (slave).
interface morningjava_seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank;
  logic [7:0]            segments;
  logic [DIGITS-1:0]     digit_en;
  logic                  slot_start;

  modport master (
    output load, data_in, dp_in, blank,
    input  segments, digit_en, slot_start
  );

  modport slave (
    input  load, data_in, dp_in, blank,
    output segments, digit_en, slot_start
  );
endinterface

// File: rtl/morningjava_seg7_rom.sv
// Combinational hex nibble to gfedcba segment decode.
module morningjava_seg7_rom
  import morningjava_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb seg = SEG_TABLE[nibble];

endmodule

// File: rtl/morningjava_seg7_scan.sv
// Time-multiplexed hex display driver: one digit per refresh slot, with a dead
// cycle at each slot start, leading-zero suppression and selectable polarity.
module morningjava_seg7_scan
  import morningjava_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1024,
  parameter int ACTIVE_LOW  = 0,
  parameter int LZ_BLANK    = 1
) (
  input logic                  clk,
  input logic                  reset,
  morningjava_seg7_scan_if.slave bus
);

  localparam int            IW       = idx_width(DIGITS);
  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic          INACT    = inactive_level(ACTIVE_LOW);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_reg;
  logic [IW-1:0]       idx_reg;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;
  logic [7:0]          segments_reg;
  logic [DIGITS-1:0]   digit_en_reg;
  logic                slot_start_reg;

  logic [3:0]          nibble;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   zero_above;
  logic                suppress;
  logic                dead;

  always_comb nibble = data_q[{idx_reg, 2'b00} +: 4];

  morningjava_seg7_rom u_rom (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // zero_above[i]: nibbles i..DIGITS-1 are all zero
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    assign zero_above[gi] = (data_q[4*DIGITS-1:4*gi] == '0);
  end

  always_comb begin
    dead     = (cnt_reg == '0);
    suppress = (LZ_BLANK != 0) && (idx_reg != '0) && zero_above[idx_reg];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      data_q         <= '0;
      dp_q           <= '0;
      segments_reg   <= {8{INACT}};
      digit_en_reg   <= {DIGITS{INACT}};
      slot_start_reg <= 1'b0;
    end else begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (bus.load) begin
        data_q <= bus.data_in;
        dp_q   <= bus.dp_in;
      end

      // Pins lag the counters by one cycle, so the pulse lines up with the dead cycle
      slot_start_reg <= dead;

      if (dead || bus.blank) begin
        segments_reg <= {8{INACT}};
        digit_en_reg <= {DIGITS{INACT}};
      end else begin
        segments_reg <= {dp_q[idx_reg], suppress ? 7'h00 : seg_raw} ^ {8{INACT}};
        digit_en_reg <= (DIGITS'(1) << idx_reg) ^ {DIGITS{INACT}};
      end
    end
  end

  assign bus.segments   = segments_reg;
  assign bus.digit_en   = digit_en_reg;
  assign bus.slot_start = slot_start_reg;

endmodule
